// File: rtl/psum_pass_ctrl.sv
// Pass sequencer for the column adder tree: issues N PE-block passes, accumulates
// the per-pass tree outputs lane by lane, and hands the summed vector downstream.
module psum_pass_ctrl #(
  parameter int LANES  = 8,
  parameter int DW     = 32,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PASS_W-1:0] num_passes,
  output logic              busy,
  input  logic              pe_valid,
  output logic              pe_ack,
  output logic              tree_en,
  input  logic              tree_valid,
  input  logic [DW-1:0]     tree_data [0:LANES-1],
  output logic [DW-1:0]     out_data  [0:LANES-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT
  } state_t;

  localparam logic [PASS_W:0] CNT_ONE = (PASS_W + 1)'(1);

  state_t          state_reg, state_next;
  // Counters carry one extra bit so a full 2^PASS_W-1 pass job never wraps.
  logic [PASS_W:0] num_reg, num_next;
  logic [PASS_W:0] issued_reg, issued_next;
  logic [PASS_W:0] received_reg, received_next;
  logic            done_reg, done_next;
  logic            acc_clear;
  logic            acc_add;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      num_reg      <= '0;
      issued_reg   <= '0;
      received_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      num_reg      <= num_next;
      issued_reg   <= issued_next;
      received_reg <= received_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    num_next      = num_reg;
    issued_next   = issued_reg;
    received_next = received_reg;
    done_next     = 1'b0;
    acc_clear     = 1'b0;
    acc_add       = 1'b0;
    tree_en       = 1'b0;
    out_valid     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (num_passes != '0) begin
            num_next      = {1'b0, num_passes};
            issued_next   = '0;
            received_next = '0;
            acc_clear     = 1'b1;
            state_next    = S_RUN;
          end else begin
            // Empty job completes immediately without touching the tree.
            done_next = 1'b1;
          end
        end
      end
      S_RUN: begin
        tree_en = pe_valid && (issued_reg < num_reg);
        if (tree_en) begin
          issued_next = issued_reg + CNT_ONE;
        end
        if (tree_valid && (received_reg < num_reg)) begin
          acc_add       = 1'b1;
          received_next = received_reg + CNT_ONE;
          if ((received_reg + CNT_ONE) == num_reg) begin
            state_next = S_OUT;
          end
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_reg != S_IDLE);
  assign pe_ack = tree_en;
  assign done   = done_reg;

  // One accumulator per lane; sums wrap modulo 2^DW.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DW-1:0] lane_acc_reg;

      always_ff @(posedge clk) begin
        if (rst || acc_clear) begin
          lane_acc_reg <= '0;
        end else if (acc_add) begin
          lane_acc_reg <= lane_acc_reg + tree_data[gi];
        end
      end

      assign out_data[gi] = (state_reg == S_OUT) ? lane_acc_reg : '0;
    end
  endgenerate

endmodule

// File: tb/tb_psum_pass_ctrl.sv
// Scoreboard bench for psum_pass_ctrl: a tree model returns planned vectors,
// expected sums are queued at job start and checked by a separate monitor.
module tb_psum_pass_ctrl;

  localparam int LANES  = 8;
  localparam int DW     = 32;
  localparam int PASS_W = 8;

  typedef logic [LANES-1:0][DW-1:0] vec_t;
  typedef struct {
    int   n;
    vec_t sum;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [PASS_W-1:0] num_passes;
  logic              busy;
  logic              pe_valid;
  logic              pe_ack;
  logic              tree_en;
  logic              tree_valid;
  logic [DW-1:0]     tree_data [0:LANES-1];
  logic [DW-1:0]     out_data  [0:LANES-1];
  logic              out_valid;
  logic              out_ready;
  logic              done;

  int   errors = 0;
  int   checks = 0;
  vec_t vec_q[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  psum_pass_ctrl #(.LANES(LANES), .DW(DW), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_passes(num_passes), .busy(busy),
    .pe_valid(pe_valid), .pe_ack(pe_ack), .tree_en(tree_en), .tree_valid(tree_valid),
    .tree_data(tree_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t out_vec();
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = out_data[i];
    return v;
  endfunction

  // Adder tree model: a result appears one cycle after each observed tree_en.
  initial begin
    logic en_s;
    vec_t v;
    tree_valid = 1'b0;
    for (int i = 0; i < LANES; i++) tree_data[i] = '0;
    forever begin
      @(negedge clk);
      en_s = tree_en;
      @(posedge clk);
      #1;
      tree_valid = en_s;
      if (en_s && vec_q.size() > 0) begin
        v = vec_q.pop_front();
        for (int i = 0; i < LANES; i++) tree_data[i] = v[i];
      end else begin
        for (int i = 0; i < LANES; i++) tree_data[i] = $urandom;
      end
    end
  end

  // Monitor: done timing, output hold under backpressure, scoreboard compare.
  initial begin
    logic done_exp;
    logic hold;
    vec_t held;
    int   en_cnt;
    exp_t e;
    vec_t got;
    done_exp = 1'b0;
    hold     = 1'b0;
    en_cnt   = 0;
    forever begin
      @(negedge clk);
      check("done_pulse", done, done_exp);
      if (!pe_valid) check("en_without_pe", tree_en, 0);
      if (hold && !rst) begin
        check("hold_valid", out_valid, 1);
        got = out_vec();
        check("hold_data_lo", got[0], held[0]);
        check("hold_data_hi", got[LANES-1], held[LANES-1]);
      end
      if (rst) begin
        done_exp = 1'b0;
        hold     = 1'b0;
        en_cnt   = 0;
      end else begin
        if (tree_en) en_cnt++;
        done_exp = start && !busy && (num_passes == '0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got a result with no job pending");
          end else begin
            e   = exp_q.pop_front();
            got = out_vec();
            for (int i = 0; i < LANES; i++)
              check($sformatf("sum_lane%0d", i), got[i], e.sum[i]);
            check("tree_en_count", en_cnt, e.n);
            $display("job n=%0d done: lane0=%0h lane7=%0h", e.n, got[0], got[LANES-1]);
          end
          en_cnt   = 0;
          done_exp = 1'b1;
          hold     = 1'b0;
        end else if (out_valid) begin
          hold = 1'b1;
          held = out_vec();
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  function automatic logic pe_for(input int pmode, input int k);
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    case (pmode)
      0: return 1'b1;
      1: return (k >= 1 && k <= 6) ? logic'(pat[k-1]) : 1'b1;
      2: return logic'($urandom_range(0, 1));
      default: return (k == 1 || k == 2 || k == 5);
    endcase
  endfunction

  // vmode: 0 random, 1 lane i = i+1, 2 wrap pattern on lane 0.
  // pmode: pe_valid pattern. rmode: 0 ready, 1 random, 2 low for 5 OUT cycles.
  task automatic run_job(input int n, input int vmode, input int pmode, input int rmode,
                         input bit lat_chk, input bit poke, input int abort_k);
    vec_t v, sum;
    int   iss, first_ov, ov_cnt, k;
    bit   finished;
    logic exp_en;
    sum = '0;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < LANES; i++) begin
        case (vmode)
          1: v[i] = DW'(i + 1);
          2: v[i] = (i == 0) ? ((p == 0) ? 32'hFFFF_FFFF : 32'h2) : $urandom;
          default: v[i] = $urandom;
        endcase
        sum[i] = sum[i] + v[i];
      end
      vec_q.push_back(v);
    end
    if (n > 0) exp_q.push_back('{n: n, sum: sum});
    iss      = 0;
    first_ov = -1;
    ov_cnt   = 0;
    finished = 1'b0;
    for (k = 0; k < 2000 && !finished; k++) begin
      @(posedge clk);
      #1;
      start      = (k == 0) || (poke && k == 2);
      num_passes = (k == 0) ? n[PASS_W-1:0] : PASS_W'($urandom);
      pe_valid   = pe_for(pmode, k);
      rst        = (abort_k > 0 && k == abort_k);
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = logic'($urandom_range(0, 1));
        default: out_ready = (ov_cnt >= 5);
      endcase
      @(negedge clk);
      if (abort_k > 0 && k == abort_k + 1) begin
        check("abort_busy", busy, 0);
        check("abort_tree_en", tree_en, 0);
        check("abort_pe_ack", pe_ack, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_vec(), 0);
        void'(exp_q.pop_back());
        vec_q.delete();
        $display("job n=%0d aborted by reset at cycle %0d", n, abort_k);
        return;
      end
      if (n == 0) begin
        check("zero_busy", busy, 0);
        check("zero_tree_en", tree_en, 0);
        if (k == 1) begin
          $display("job n=0 done");
          finished = 1'b1;
        end
      end else if (!rst) begin
        if (k >= 1 && busy && !out_valid) begin
          exp_en = pe_valid && (iss < n);
          check("tree_en", tree_en, exp_en);
          check("pe_ack", pe_ack, exp_en);
          if (exp_en) iss++;
        end
        if (out_valid) begin
          if (first_ov < 0) first_ov = k;
          ov_cnt++;
          if (out_ready) begin
            if (lat_chk) begin
              check("first_out_valid_cycle", first_ov, n + 2);
              check("handshake_cycle", k, n + 2);
            end
            finished = 1'b1;
          end
        end
      end
    end
    if (!finished && abort_k == 0) begin
      checks++;
      errors++;
      $display("FAIL job_timeout: n=%0d not finished after %0d cycles", n, k);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num_passes = '0;
    pe_valid   = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_tree_en", tree_en, 0);
    check("rst_pe_ack", pe_ack, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_vec(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_job(4, 1, 0, 0, 1'b1, 1'b0, 0);   // basic, latency
    run_job(3, 0, 1, 0, 1'b0, 1'b0, 0);   // stalled PE
    run_job(3, 0, 0, 2, 1'b0, 1'b0, 0);   // backpressure
    run_job(2, 2, 0, 0, 1'b0, 1'b0, 0);   // lane wrap
    run_job(0, 0, 0, 0, 1'b0, 1'b0, 0);   // empty job
    run_job(5, 0, 0, 0, 1'b1, 1'b1, 0);   // start during RUN
    run_job(5, 0, 3, 0, 1'b0, 1'b0, 4);   // reset after 2 of 5
    run_job(1, 0, 0, 0, 1'b1, 1'b0, 0);   // fresh job after abort
    run_job(255, 0, 0, 0, 1'b1, 1'b0, 0); // full-length job
    for (int j = 0; j < 20; j++)
      run_job($urandom_range(0, 12), 0, 2, 1, 1'b0, logic'($urandom_range(0, 1)), 0);

    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
